pwm_capture: RTL and testbench

- Receive-side counterpart to the team's PWM generator. It measures the high time and period of an incoming PWM waveform, for example a motor-driver feedback line or a loop-back of our own PWM_Out.
- It produces an 8-bit duty value on the same 0..255 scale the generator uses.
- It sits between an external PWM pin and the control logic, and flags lines stuck high or stuck low.

---
 rtl/pwm_capture_if.sv | 25 ++
 rtl/pwm_capture.sv | 214 +++++++++++++++++++++
 tb/tb_pwm_capture.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// Signal bundle between the PWM pin/control logic and pwm_capture.
// The master side drives enable and the pin; the slave side returns measurements.
interface pwm_capture_if #(
  parameter int CNT_W  = 16,
  parameter int DUTY_W = 8
);
  logic              enable;
  logic              pwm_in;
  logic [CNT_W-1:0]  high_count;
  logic [CNT_W-1:0]  period_count;
  logic [DUTY_W-1:0] duty;
  logic              duty_valid;
  logic              stuck;
  logic              overrun;

  modport master (
    output enable, pwm_in,
    input  high_count, period_count, duty, duty_valid, stuck, overrun
  );

  modport slave (
    input  enable, pwm_in,
    output high_count, period_count, duty, duty_valid, stuck, overrun
  );
endinterface

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input and reports an
// 8-bit-scale duty via a serial restoring divider; flags stuck-high/low lines.
module pwm_capture #(
  parameter int          CNT_W   = 16,
  parameter int          DUTY_W  = 8,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input logic          clk,
  input logic          reset_n,
  pwm_capture_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HI, LO} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
  localparam int               IT_W    = $clog2(DUTY_W) + 1;
  localparam logic [IT_W-1:0]  IT_LAST = IT_W'(DUTY_W - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic              s1_q, s1_d, s2_q, s2_d, sd_q, sd_d;
  logic              rise, fall;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d, pcnt_q, pcnt_d, tcnt_q, tcnt_d;
  logic              busy_q, busy_d;
  logic [IT_W-1:0]   it_q, it_d;
  logic [CNT_W-1:0]  rem_q, rem_d, dvsr_q, dvsr_d, dh_q, dh_d;
  logic [DUTY_W-1:0] quo_q, quo_d;
  logic              clamp_q, clamp_d;
  logic [CNT_W-1:0]  hc_q, hc_d, pc_q, pc_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              dv_q, dv_d, stuck_q, stuck_d, ovr_q, ovr_d;
  logic [CNT_W:0]    rem_sh;
  logic              ge;
  logic [DUTY_W-1:0] quo_nx;
  logic              latch, timeout;

  assign rise = s2_q & ~sd_q;
  assign fall = ~s2_q & sd_q;

  always_comb begin
    s1_d    = bus.pwm_in;
    s2_d    = s1_q;
    sd_d    = s2_q;
    state_d = state_q;
    hcnt_d  = hcnt_q;
    pcnt_d  = pcnt_q;
    tcnt_d  = tcnt_q;
    busy_d  = busy_q;
    it_d    = it_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    dh_d    = dh_q;
    quo_d   = quo_q;
    clamp_d = clamp_q;
    hc_d    = hc_q;
    pc_d    = pc_q;
    duty_d  = duty_q;
    dv_d    = 1'b0;
    stuck_d = stuck_q;
    ovr_d   = 1'b0;
    latch   = 1'b0;
    timeout = 1'b0;

    // Low dividend bits are all zero, so each step just shifts in a 0.
    rem_sh = {rem_q, 1'b0};
    ge     = rem_sh >= {1'b0, dvsr_q};
    quo_nx = DUTY_W'({quo_q, ge});
    if (busy_q) begin
      rem_d = CNT_W'(ge ? rem_sh - {1'b0, dvsr_q} : rem_sh);
      quo_d = quo_nx;
      it_d  = it_q + 1'b1;
      if (it_q == IT_LAST) begin
        busy_d  = 1'b0;
        dv_d    = 1'b1;
        stuck_d = 1'b0;
        hc_d    = dh_q;
        pc_d    = dvsr_q;
        duty_d  = clamp_q ? '1 : quo_nx;
      end
    end

    case (state_q)
      IDLE: if (rise) begin
        state_d = HI;
        hcnt_d  = ONE;
        pcnt_d  = ONE;
        tcnt_d  = '0;
      end
      HI: begin
        pcnt_d = sat_inc(pcnt_q);
        if (fall) begin
          state_d = LO;
          tcnt_d  = '0;
        end else begin
          hcnt_d = sat_inc(hcnt_q);
          tcnt_d = sat_inc(tcnt_q);
          timeout = (tcnt_q >= TO_CNT);
        end
      end
      LO: if (rise) begin
        latch   = 1'b1;
        state_d = HI;
        hcnt_d  = ONE;
        pcnt_d  = ONE;
        tcnt_d  = '0;
      end else begin
        pcnt_d  = sat_inc(pcnt_q);
        tcnt_d  = sat_inc(tcnt_q);
        timeout = (tcnt_q >= TO_CNT);
      end
      default: state_d = IDLE;
    endcase

    // A busy divider keeps its sample; the new one is dropped.
    if (latch) begin
      if (busy_q) begin
        ovr_d = 1'b1;
      end else begin
        busy_d  = 1'b1;
        it_d    = '0;
        rem_d   = hcnt_q;
        dvsr_d  = pcnt_q;
        dh_d    = hcnt_q;
        quo_d   = '0;
        clamp_d = (hcnt_q >= pcnt_q);
      end
    end

    if (timeout) begin
      state_d = IDLE;
      hcnt_d  = '0;
      pcnt_d  = '0;
      tcnt_d  = '0;
      busy_d  = 1'b0;
      dv_d    = 1'b1;
      stuck_d = 1'b1;
      hc_d    = '0;
      pc_d    = '0;
      duty_d  = (state_q == HI) ? '1 : '0;
    end

    // Disable freezes reported values and drops any in-flight division.
    if (!bus.enable) begin
      state_d = IDLE;
      hcnt_d  = '0;
      pcnt_d  = '0;
      tcnt_d  = '0;
      busy_d  = 1'b0;
      dv_d    = 1'b0;
      ovr_d   = 1'b0;
      hc_d    = hc_q;
      pc_d    = pc_q;
      duty_d  = duty_q;
      stuck_d = stuck_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      sd_q    <= 1'b0;
      state_q <= IDLE;
      hcnt_q  <= '0;
      pcnt_q  <= '0;
      tcnt_q  <= '0;
      busy_q  <= 1'b0;
      it_q    <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      dh_q    <= '0;
      quo_q   <= '0;
      clamp_q <= 1'b0;
      hc_q    <= '0;
      pc_q    <= '0;
      duty_q  <= '0;
      dv_q    <= 1'b0;
      stuck_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      sd_q    <= sd_d;
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      pcnt_q  <= pcnt_d;
      tcnt_q  <= tcnt_d;
      busy_q  <= busy_d;
      it_q    <= it_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      dh_q    <= dh_d;
      quo_q   <= quo_d;
      clamp_q <= clamp_d;
      hc_q    <= hc_d;
      pc_q    <= pc_d;
      duty_q  <= duty_d;
      dv_q    <= dv_d;
      stuck_q <= stuck_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.high_count   = hc_q;
  assign bus.period_count = pc_q;
  assign bus.duty         = duty_q;
  assign bus.duty_valid   = dv_q;
  assign bus.stuck        = stuck_q;
  assign bus.overrun      = ovr_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus pushes expected reports, a
// negedge monitor pops them on every duty_valid and checks value and timing.
module tb_pwm_capture;
  localparam int CNT_W  = 16;
  localparam int DUTY_W = 8;
  // Long enough that a 241-cycle low phase does not time out.
  localparam int TO     = 300;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  pwm_capture_if #(.CNT_W(CNT_W), .DUTY_W(DUTY_W)) bus ();

  pwm_capture #(.CNT_W(CNT_W), .DUTY_W(DUTY_W), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int hc;
    int pc;
    int duty;
    int stuck;
    int at;
    int tol;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   ovr_seen = 0;
  int   exp_ovr = 0;

  // reference model of what has been reported / what is in flight
  bit armed = 1'b0;
  int prev_h, prev_p, prev_d;
  int busy_lim = -100;
  int last_hc = 0, last_pc = 0, last_duty = 0, last_stuck = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.overrun === 1'b1) ovr_seen++;
    if (bus.duty_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_duty_valid", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("high_count", 32'(bus.high_count), e.hc);
        chk("period_count", 32'(bus.period_count), e.pc);
        chk("duty", 32'(bus.duty), e.duty);
        chk("stuck", 32'(bus.stuck), e.stuck);
        n_chk++;
        if (cyc < e.at - e.tol || cyc > e.at + e.tol) begin
          n_fail++;
          $display("FAIL dv_cycle: got %0d expected %0d (+/-%0d)", cyc, e.at, e.tol);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pin rises now; the period that ends here is reported 11 posedges later
  // (2 sync + 1 detect + 8 divide) unless the divider is still busy.
  task automatic do_rise(input int h, input int p, input int d);
    int k;
    k = cyc;
    bus.pwm_in = 1'b1;
    if (armed) begin
      if (k <= busy_lim) begin
        exp_ovr++;
      end else begin
        sbq.push_back('{prev_h, prev_p, prev_d, 0, k + 11, 0});
        busy_lim   = k + 8;
        last_hc    = prev_h;
        last_pc    = prev_p;
        last_duty  = prev_d;
        last_stuck = 0;
      end
    end
    armed  = 1'b1;
    prev_h = h;
    prev_p = p;
    prev_d = d;
  endtask

  task automatic run(input int h, input int l, input int d, input int n);
    repeat (n) begin
      do_rise(h, h + l, d);
      tick(h);
      bus.pwm_in = 1'b0;
      tick(l);
    end
  endtask

  task automatic stuck_high(input int hold);
    int k;
    k = cyc;
    do_rise(0, 0, 0);
    sbq.push_back('{0, 0, 255, 1, k + 4 + TO, 1});
    armed = 1'b0;
    last_hc = 0; last_pc = 0; last_duty = 255; last_stuck = 1;
    tick(hold);
    bus.pwm_in = 1'b0;
    tick(20);
  endtask

  task automatic stuck_low(input int h, input int hold);
    int kf;
    do_rise(0, 0, 0);
    tick(h);
    kf = cyc;
    bus.pwm_in = 1'b0;
    sbq.push_back('{0, 0, 0, 1, kf + 4 + TO, 1});
    armed = 1'b0;
    last_hc = 0; last_pc = 0; last_duty = 0; last_stuck = 1;
    tick(hold);
  endtask

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.enable = 1'b1;
    bus.pwm_in = 1'b0;
    #1 reset_n = 1'b0;
    tick(3);
    chk("rst_high_count", 32'(bus.high_count), 0);
    chk("rst_period_count", 32'(bus.period_count), 0);
    chk("rst_duty", 32'(bus.duty), 0);
    chk("rst_duty_valid", 32'(bus.duty_valid), 0);
    chk("rst_stuck", 32'(bus.stuck), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    reset_n = 1'b1;
    tick(5);

    run(15, 241, 15, 4);   // 15*256/256 = 15
    run(64, 136, 81, 4);   // floor(64*256/200) = 81
    run(2, 4, 85, 8);      // floor(2*256/6) = 85, period shorter than divider
    run(15, 241, 15, 2);
    chk("overrun_count", 32'(ovr_seen), 32'(exp_ovr));

    stuck_high(TO + 30);
    chk("stuck_high_level", 32'(bus.stuck), 1);
    chk("stuck_high_duty", 32'(bus.duty), 255);
    run(15, 241, 15, 3);
    chk("stuck_cleared", 32'(bus.stuck), 0);

    stuck_low(15, TO + 30);
    chk("stuck_low_level", 32'(bus.stuck), 1);
    chk("stuck_low_duty", 32'(bus.duty), 0);
    run(15, 241, 15, 2);

    // enable dropped mid-division: nothing reported, outputs frozen
    chk("queue_empty_pre_en", 32'(sbq.size()), 0);
    bus.pwm_in = 1'b1;
    armed = 1'b0;
    tick(5);
    bus.enable = 1'b0;
    tick(10);
    bus.pwm_in = 1'b0;
    tick(20);
    chk("en_hold_high_count", 32'(bus.high_count), 32'(last_hc));
    chk("en_hold_period_count", 32'(bus.period_count), 32'(last_pc));
    chk("en_hold_duty", 32'(bus.duty), 32'(last_duty));
    chk("en_hold_stuck", 32'(bus.stuck), 32'(last_stuck));
    bus.enable = 1'b1;
    tick(30);
    run(15, 241, 15, 3);

    // reset mid-division clears everything immediately
    bus.pwm_in = 1'b1;
    tick(5);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_high_count", 32'(bus.high_count), 0);
    chk("mid_rst_period_count", 32'(bus.period_count), 0);
    chk("mid_rst_duty", 32'(bus.duty), 0);
    chk("mid_rst_duty_valid", 32'(bus.duty_valid), 0);
    chk("mid_rst_stuck", 32'(bus.stuck), 0);
    bus.pwm_in = 1'b0;
    armed = 1'b0;
    busy_lim = -100;
    tick(3);
    reset_n = 1'b1;
    tick(20);
    run(64, 136, 81, 3);

    tick(20);
    chk("queue_empty_end", 32'(sbq.size()), 0);
    chk("overrun_count_end", 32'(ovr_seen), 32'(exp_ovr));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
